// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter: shares the single-port frame RAM between the column
// framebuffer reader (priority, real-time) and the pixel ingest writer.
// Optional starvation guard is enabled with the macro ARB_STARVE_GUARD_EN;
// without it the reader has strict priority and the writer may starve.
module frame_ram_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 24,
  parameter int RD_LAT       = 2,
  parameter int MAX_RD_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  // The state records what the previous cycle granted, so it directly
  // describes the RAM slot being driven this cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              guard_fire;
  logic              rd_issue;
  logic [RD_LAT-1:0] valid_pipe;

  // Reject configurations the read-return pipeline and guard cannot support
  if (RD_LAT < 1 || RD_LAT > 4 || MAX_RD_BURST < 1) begin : g_bad_params
    $error("frame_ram_arbiter: RD_LAT must be 1..4 and MAX_RD_BURST >= 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_RD_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_BURST);

  logic [SW-1:0] streak;

  // Count reads granted while a write waits; any write grant or idle writer resets it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (wr_gnt || !wr_req) begin
      streak <= '0;
    end else if (rd_gnt && (streak != STREAK_MAX)) begin
      streak <= streak + 1'b1;
    end
  end

  assign guard_fire = (streak == STREAK_MAX) && wr_req;
`else
  assign guard_fire = 1'b0;
`endif

  // Reader wins unless the guard steals this slot; writer takes whatever is left
  assign rd_gnt = rd_req && !guard_fire;
  assign wr_gnt = wr_req && !rd_gnt;

  // State register: remembers last cycle's grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state simply follows this cycle's grant
  always_comb begin
    next_state = IDLE;
    if (rd_gnt) begin
      next_state = READ;
    end else if (wr_gnt) begin
      next_state = WRITE;
    end
  end

  // RAM control decoded from the registered state
  always_comb begin
    busy     = (state != IDLE);
    ram_we   = (state == WRITE);
    rd_issue = (state == READ);
  end

  // Address holds when nothing is granted so the RAM sees a stable bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr <= '0;
    end else if (rd_gnt) begin
      ram_addr <= rd_addr;
    end else if (wr_gnt) begin
      ram_addr <= wr_addr;
    end
  end

  // Write data only loads on a write grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wdata <= '0;
    end else if (wr_gnt) begin
      ram_wdata <= wr_data;
    end
  end

  // Track each issued read through the RAM latency; reset drops in-flight reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
      end
    end
  end

  assign rd_valid = valid_pipe[RD_LAT-1];
  assign rd_data  = ram_rdata;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// tb_frame_ram_arbiter: directed and randomized checks of frame_ram_arbiter
// against a cycle-numbered reference model of the arbitration rules.
module tb_frame_ram_arbiter;

   localparam int AW           = 32;
   localparam int DW           = 24;
   localparam int RD_LAT       = 2;
   localparam int MAX_RD_BURST = 4;

`ifdef ARB_STARVE_GUARD_EN
   localparam bit GuardOn = 1'b1;
`else
   localparam bit GuardOn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          rdReq;
   logic [AW-1:0] rdAddr;
   logic          rdGnt;
   logic [DW-1:0] rdData;
   logic          rdValid;
   logic          wrReq;
   logic [AW-1:0] wrAddr;
   logic [DW-1:0] wrData;
   logic          wrGnt;
   logic [AW-1:0] ramAddr;
   logic          ramWe;
   logic [DW-1:0] ramWdata;
   logic [DW-1:0] ramRdata;
   logic          busy;

   always #5 clk = ~clk;

   frame_ram_arbiter #(
      .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_RD_BURST(MAX_RD_BURST)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_req(rdReq), .rd_addr(rdAddr), .rd_gnt(rdGnt),
      .rd_data(rdData), .rd_valid(rdValid),
      .wr_req(wrReq), .wr_addr(wrAddr), .wr_data(wrData), .wr_gnt(wrGnt),
      .ram_addr(ramAddr), .ram_we(ramWe), .ram_wdata(ramWdata),
      .ram_rdata(ramRdata), .busy(busy)
   );

   // RAM stand-in: contents are a fixed hash of the address, returned RD_LAT cycles after issue
   function automatic logic [DW-1:0] ramWord(input logic [AW-1:0] a);
      return a[23:0] ^ {3{a[31:24]}} ^ 24'h5A3C96;
   endfunction

   logic [AW-1:0] addrHist [RD_LAT];

   // Delay line of the address the RAM saw, to emulate its read latency
   always @(posedge clk) begin
      addrHist[0] <= ramAddr;
      for (int i = 1; i < RD_LAT; i++) addrHist[i] <= addrHist[i-1];
   end

   assign ramRdata = ramWord(addrHist[RD_LAT-1]);

   // Reference model state
   typedef struct {
      int            due;
      logic [AW-1:0] addr;
   } pending_t;

   pending_t      pend[$];
   int            cycle;
   int            streakM;
   logic [AW-1:0] expRamAddr;
   logic [DW-1:0] expRamWdata;
   logic          expRamWe;
   logic          expBusy;
   logic          lastWrGnt;
   int            rdGrantCount;
   int            wrGrantCount;
   int            errors;
   int            checks;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive requests, check against the model, then advance the model
   task automatic applyStimulus(input logic rq, input logic [AW-1:0] ra,
                                input logic wq, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd);
      logic fire, egRd, egWr, expValid;
      rdReq  = rq;
      rdAddr = ra;
      wrReq  = wq;
      wrAddr = wa;
      wrData = wd;
      @(negedge clk);
      fire = GuardOn && (streakM == MAX_RD_BURST) && wq;
      egRd = rq && !fire;
      egWr = wq && !egRd;
      checkOutput("rd_gnt", 64'(rdGnt), 64'(egRd));
      checkOutput("wr_gnt", 64'(wrGnt), 64'(egWr));
      checkOutput("ram_we", 64'(ramWe), 64'(expRamWe));
      checkOutput("busy", 64'(busy), 64'(expBusy));
      checkOutput("ram_addr", 64'(ramAddr), 64'(expRamAddr));
      if (expRamWe) checkOutput("ram_wdata", 64'(ramWdata), 64'(expRamWdata));
      expValid = (pend.size() > 0) && (pend[0].due == cycle);
      checkOutput("rd_valid", 64'(rdValid), 64'(expValid));
      if (expValid) begin
         checkOutput("rd_data", 64'(rdData), 64'(ramWord(pend[0].addr)));
         void'(pend.pop_front());
      end
      if (rdGnt) rdGrantCount++;
      if (wrGnt) wrGrantCount++;
      lastWrGnt = wrGnt;
      @(posedge clk);
      #1;
      expBusy  = egRd || egWr;
      expRamWe = egWr;
      if (egRd) begin
         expRamAddr = ra;
         pend.push_back('{due: cycle + RD_LAT + 1, addr: ra});
      end else if (egWr) begin
         expRamAddr  = wa;
         expRamWdata = wd;
      end
      if (egWr || !wq) streakM = 0;
      else if (egRd && streakM < MAX_RD_BURST) streakM++;
      cycle++;
   endtask

   // Assert reset, check the cleared outputs immediately, hold for n idle cycles
   task automatic doReset(input int n);
      rst = 1'b1;
      #1;
      pend.delete();
      streakM     = 0;
      expRamAddr  = '0;
      expRamWdata = '0;
      expRamWe    = 1'b0;
      expBusy     = 1'b0;
      checkOutput("rst_ram_we", 64'(ramWe), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_rd_valid", 64'(rdValid), 64'd0);
      checkOutput("rst_ram_addr", 64'(ramAddr), 64'd0);
      checkOutput("rst_ram_wdata", 64'(ramWdata), 64'd0);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0);
      rst = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0);
   endtask

   // Directed scenarios first, then a randomized run under the writer hold rule
   initial begin
      logic          rq, wq;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      errors = 0;
      checks = 0;
      cycle = 0;
      streakM = 0;
      lastWrGnt = 1'b0;
      rst = 1'b1;
      rdReq = 1'b0; rdAddr = '0;
      wrReq = 1'b0; wrAddr = '0; wrData = '0;
      @(posedge clk);
      #1;
      doReset(2);

      $display("[TB] read-only burst");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, AW'(32'h10 + 8 * i), 1'b0, '0, '0);
      idleCycles(6);

      $display("[TB] single write");
      applyStimulus(1'b0, '0, 1'b1, 32'h40, 24'hA1B2C3);
      idleCycles(2);

      $display("[TB] sustained contention");
      rdGrantCount = 0;
      wrGrantCount = 0;
      wa = 32'h100;
      wd = 24'h000001;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, AW'(32'h200 + i), 1'b1, wa, wd);
         if (lastWrGnt) begin
            wa = wa + 1;
            wd = wd + 1;
         end
      end
      checkOutput("contend_rd_grants", 64'(rdGrantCount), GuardOn ? 64'd16 : 64'd20);
      checkOutput("contend_wr_grants", 64'(wrGrantCount), GuardOn ? 64'd4 : 64'd0);
      applyStimulus(1'b0, '0, 1'b1, wa, wd);
      checkOutput("write_after_read_drop", 64'(lastWrGnt), 64'd1);
      idleCycles(4);

      $display("[TB] withdrawn write");
      applyStimulus(1'b1, 32'h300, 1'b1, 32'h77, 24'h777777);
      applyStimulus(1'b1, 32'h301, 1'b0, '0, '0);
      applyStimulus(1'b1, 32'h302, 1'b0, '0, '0);
      idleCycles(5);

      $display("[TB] reset with reads in flight");
      applyStimulus(1'b1, 32'h500, 1'b0, '0, '0);
      applyStimulus(1'b1, 32'h508, 1'b0, '0, '0);
      doReset(1);
      idleCycles(6);

      $display("[TB] randomized traffic");
      wq = 1'b0;
      wa = '0;
      wd = '0;
      for (int i = 0; i < 400; i++) begin
         rq = ($urandom_range(0, 99) < 70);
         if (wq && !lastWrGnt) begin
            if ($urandom_range(0, 9) == 0) wq = 1'b0;
         end else begin
            wq = ($urandom_range(0, 1) == 1);
            wa = AW'($urandom);
            wd = DW'($urandom);
         end
         applyStimulus(rq, AW'($urandom), wq, wa, wd);
         if (i == 200) doReset(1);
      end
      idleCycles(RD_LAT + 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
